// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: round-robin write-back arbiter in front of the register file.
// Three requesters (ALU, DM load, MDU) compete for the single GRF write port.
// A grant is visible on req_ready in the same cycle. The write reaches the
// register file one cycle later. pend_mask tells the ID-stage stall logic which
// registers still have a write in flight.
module grf_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_valid,
   input  logic [14:0] req_a3,
   input  logic [95:0] req_wd,
   input  logic [95:0] req_pc,
   output logic [2:0]  req_ready,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_pc,
   output logic [31:0] pend_mask,
   output logic [15:0] conflict_cnt
);

   logic [1:0]  rr_ptr;
   logic [2:0]  grant_oh;
   logic        grant_any;
   logic [1:0]  grant_idx;
   logic [1:0]  cand;
   logic [4:0]  g_a3;
   logic [31:0] g_wd;
   logic [31:0] g_pc;
   logic [31:0] set_vec;
   logic [31:0] clr_vec;
   logic [31:0] pend_q;
   logic        multi_req;

   // (base + off) mod 3 for pointer values 0..2.
   function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 3'd3) sum = sum - 3'd3;
      return sum[1:0];
   endfunction

   // Search for the first valid requester, starting at rr_ptr. Nothing is granted while in reset.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      grant_oh  = 3'b000;
      grant_any = 1'b0;
      grant_idx = 2'd0;
      cand      = 2'd0;
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            cand = wrap_add(rr_ptr, 2'(k));
            if (!grant_any && req_valid[cand]) begin
               grant_any      = 1'b1;
               grant_idx      = cand;
               grant_oh[cand] = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant_oh;

   // Route the granted requester's address, data and PC toward the output stage.
   always_comb begin
      g_a3 = req_a3[4:0];
      g_wd = req_wd[31:0];
      g_pc = req_pc[31:0];
      case (grant_idx)
         2'd1: begin
            g_a3 = req_a3[9:5];
            g_wd = req_wd[63:32];
            g_pc = req_pc[63:32];
         end
         2'd2: begin
            g_a3 = req_a3[14:10];
            g_wd = req_wd[95:64];
            g_pc = req_pc[95:64];
         end
         default: ;
      endcase
   end

   // Pending-write bookkeeping: the granted register is set and the register being written is cleared.
   always_comb begin
      set_vec = 32'h0;
      clr_vec = 32'h0;
      if (grant_any) set_vec[g_a3] = 1'b1;
      if (grf_we)    clr_vec[grf_a3] = 1'b1;
   end

   // Stall logic must see the write in the acceptance cycle, so the grant bit is ORed in combinationally.
   assign pend_mask = (pend_q | set_vec) & ~32'h1;

   assign multi_req = (req_valid[0] & req_valid[1]) |
                      (req_valid[0] & req_valid[2]) |
                      (req_valid[1] & req_valid[2]);

   // Round-robin pointer: moves past the granted requester and holds when nothing is granted.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so that all registers update together.
      if (!rst)           rr_ptr <= 2'd0;
      else if (grant_any) rr_ptr <= wrap_add(grant_idx, 2'd1);
   end

   // Output stage: the accepted write appears one cycle after acceptance, and writes to $0 are suppressed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grf_we <= 1'b0;
         grf_a3 <= 5'd0;
         grf_wd <= 32'h0;
         grf_pc <= 32'h0;
      end else if (grant_any) begin
         grf_we <= (g_a3 != 5'd0);
         grf_a3 <= g_a3;
         grf_wd <= g_wd;
         grf_pc <= g_pc;
      end else begin
         grf_we <= 1'b0;
      end
   end

   // Registered pending bits. Set wins over clear, so re-granting the register being written keeps it pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend_q <= 32'h0;
      else      pend_q <= ((pend_q & ~clr_vec) | set_vec) & ~32'h1;
   end

   // Saturating count of cycles where two or more requesters contend.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       conflict_cnt <= 16'h0;
      else if (multi_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
   end

endmodule
